// File: rtl/seg_scan_if.sv
// seg_scan_if: display data/enables in, anode/segment pins out.
// SEG_BLINK_EN adds the blinkMask signal.
interface seg_scan_if;
    logic [31:0] display;
    logic [7:0]  displayEnable;
`ifdef SEG_BLINK_EN
    logic [7:0]  blinkMask;
`endif
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
`ifdef SEG_BLINK_EN
    modport master (output display, displayEnable, blinkMask, input an, seg, dp);
    modport slave  (input display, displayEnable, blinkMask, output an, seg, dp);
`else
    modport master (output display, displayEnable, input an, seg, dp);
    modport slave  (input display, displayEnable, output an, seg, dp);
`endif
endinterface

// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed common-anode 7-segment driver with frame-latched shadow.
// SEG_BLINK_EN adds per-digit blinking (blinkMask, BLINK_FRAMES).
module seg_scan #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 16
`endif
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   sh_disp_q, sh_disp_d;
    logic [7:0]    sh_en_q, sh_en_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          wrap, load, blink_off, lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign wrap = cnt_q == CW'(TICK_DIV - 1);
    // Last cycle of the frame: shadow takes the inputs for the whole next frame
    assign load = wrap && idx_q == 3'd7;

`ifdef SEG_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] fr_q, fr_d;
    logic          phase_q, phase_d, fr_end;
    logic [7:0]    sh_mask_q, sh_mask_d;

    always_comb begin
        fr_end    = load && fr_q == FW'(BLINK_FRAMES - 1);
        fr_d      = fr_end ? '0 : load ? fr_q + 1'b1 : fr_q;
        phase_d   = phase_q ^ fr_end;
        sh_mask_d = load ? bus.blinkMask : sh_mask_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fr_q      <= '0;
            phase_q   <= 1'b1;
            sh_mask_q <= '0;
        end else begin
            fr_q      <= fr_d;
            phase_q   <= phase_d;
            sh_mask_q <= sh_mask_d;
        end
    end

    assign blink_off = ~phase_q & sh_mask_q[idx_q];
`else
    assign blink_off = 1'b0;
`endif

    assign lit = cnt_q >= CW'(BLANK_CYCLES) && sh_en_q[idx_q] && !blink_off;

    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 1'b1 : idx_q;
        sh_disp_d = load ? bus.display : sh_disp_q;
        sh_en_d   = load ? bus.displayEnable : sh_en_q;
        an_d      = lit ? ~(8'b1 << idx_q) : 8'hFF;
        seg_d     = lit ? hex7(sh_disp_q[{idx_q, 2'b00} +: 4]) : 7'h7F;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_disp_q <= '0;
            sh_en_q   <= '0;
            an_q      <= 8'hFF;
            seg_q     <= 7'h7F;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_disp_q <= sh_disp_d;
            sh_en_q   <= sh_en_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed frames with a scoreboard of per-cycle {an,seg,dp} expectations.
// Build with SEG_BLINK_EN defined to also cover blinking.
module tb_seg_scan;
    localparam int BF = 2;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan #(
        .TICK_DIV(4),
        .BLANK_CYCLES(1)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fnum = 0;
    logic [31:0] lat_d = '0;
    logic [7:0]  lat_e = '0;
    logic [7:0]  lat_m = '0;

    task automatic push_blank();
        exp_q.push_back({8'hFF, 7'h7F, 1'b1});
    endtask

    // Expected outputs for a whole frame from the values latched at its start
    task automatic push_frame();
        logic [7:0] one;
        logic       ph;
        one = 8'h01;
        ph  = ((fnum / BF) % 2) == 0;
        for (int p = 1; p <= 32; p++) begin
            int  c, i;
            logic vis;
            c   = (p - 1) % 4;
            i   = (p - 1) / 4;
            vis = c >= 1 && lat_e[i] && !(!ph && lat_m[i]);
            if (vis) exp_q.push_back({~(one << i), HEX[lat_d[4*i +: 4]], 1'b1});
            else push_blank();
        end
    endtask

    task automatic check_out(input string tag);
        logic [15:0] obs, exp;
        obs = {bus.an, bus.seg, bus.dp};
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s frame %0d: observed an/seg/dp=%h expected %h", tag, fnum, obs, exp);
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic latch_inputs();
        lat_d = bus.display;
        lat_e = bus.displayEnable;
`ifdef SEG_BLINK_EN
        lat_m = bus.blinkMask;
`endif
    endtask

    // One frame; inputs change before edge chg_p (0 = no change), rst drops before edge rst_p
    task automatic frame(input string tag, input int chg_p, input logic [31:0] nd,
                         input logic [7:0] ne, input int rst_p);
        push_frame();
        for (int p = 1; p <= 32; p++) begin
            if (p == chg_p) begin
                bus.display       = nd;
                bus.displayEnable = ne;
            end
            if (p == rst_p) begin
                rst = 1'b0;
                exp_q.delete();
                push_blank();
                cycle({tag, "_rst"});
                rst   = 1'b1;
                lat_d = '0;
                lat_e = '0;
                lat_m = '0;
                fnum  = 0;
                return;
            end
            @(posedge clk);
            if (p == 32) latch_inputs();
            #1;
            check_out(tag);
        end
        fnum++;
    endtask

    initial begin
        bus.display       = 32'h12345678;
        bus.displayEnable = 8'hFF;
`ifdef SEG_BLINK_EN
        bus.blinkMask     = 8'h01;
`endif
        for (int k = 0; k < 3; k++) begin
            push_blank();
            cycle("reset_hold");
        end
        rst = 1'b1;
        frame("first_blank", 0, 32'h0, 8'h0, 0);
        frame("scan", 5, 32'h000A000F, 8'h11, 0);
        frame("enable_gate", 5, 32'h01234567, 8'hFF, 0);
        frame("tear_old", 14, 32'h89ABCDEF, 8'hFF, 0);
        frame("tear_new", 0, 32'h0, 8'h0, 0);
        frame("mid_reset", 0, 32'h0, 8'h0, 22);
        frame("post_reset_blank", 0, 32'h0, 8'h0, 0);
        for (int k = 0; k < 5; k++) frame("post_reset_scan", 0, 32'h0, 8'h0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
